// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg
//   Shared types and helpers for the decode-stage hazard/bypass controller.
//   - sb_entry_t : one in-flight scoreboard entry. The destination field is
//                  sized for the widest supported register address. Narrower
//                  addresses are zero-extended into it.
//   - FWD_RF     : forwarding select value meaning "read the register file".
//   - sel_width  : width of a forwarding select for a given stage count.
//   - idx_width  : width of a stage index (at least 1 bit).
package hazard_scoreboard_pkg;

  localparam int REG_ADDR_MAX_W = 8;
  localparam int FWD_RF         = 0;

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_MAX_W-1:0] wbaddr;
    logic                      wen;
    logic                      is_load;
    logic                      is_csr;
  } sb_entry_t;

  function automatic int sel_width(input int num_stages);
    return $clog2(num_stages + 1);
  endfunction

  function automatic int idx_width(input int num_stages);
    return (num_stages > 1) ? $clog2(num_stages) : 1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_match.sv
// hazard_match
//   Compares one decode source operand against every scoreboard entry and
//   reports the youngest (lowest-index) in-flight writer of that register.
//   Ports:
//     entries_i  scoreboard entries, index 0 = exe
//     addr_i     source register address
//     oen_i      source read enable
//     match_o    some entry writes addr_i
//     idx_o      stage index of the youngest matching entry
//     is_load_o  that entry is a load
module hazard_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int ADDR_W     = 5,
  localparam int IDX_W     = idx_width(NUM_STAGES)
) (
  input  sb_entry_t [NUM_STAGES-1:0] entries_i,
  input  logic      [ADDR_W-1:0]     addr_i,
  input  logic                       oen_i,
  output logic                       match_o,
  output logic      [IDX_W-1:0]      idx_o,
  output logic                       is_load_o
);

  always_comb begin
    match_o   = 1'b0;
    idx_o     = '0;
    is_load_o = 1'b0;
    // x0 is hard-wired zero and never creates a dependency.
    if (oen_i && (addr_i != '0)) begin
      // Scan oldest to youngest so the youngest match overwrites the rest.
      for (int i = NUM_STAGES - 1; i >= 0; i--) begin
        if (entries_i[i].valid && entries_i[i].wen &&
            (entries_i[i].wbaddr == REG_ADDR_MAX_W'(addr_i))) begin
          match_o   = 1'b1;
          idx_o     = IDX_W'(i);
          is_load_o = entries_i[i].is_load;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Decode-stage hazard and bypass controller. Tracks the destinations of
//   NUM_STAGES post-decode stages (0 = exe, NUM_STAGES-1 = wb), stalls decode
//   on unresolvable dependencies and CSR serialisation, and selects
//   forwarding sources for rs1/rs2.
//   Build option HAZARD_SCOREBOARD_BYPASS_EN:
//     defined   - forwarding enabled, only load-use hazards stall.
//     undefined - full interlock: any dependency stalls, selects tied to 0.
//   Ports:
//     clk, reset                synchronous active-high reset
//     dec_valid                 decode holds a valid instruction
//     dec_rs1_addr/oen          source 1
//     dec_rs2_addr/oen          source 2
//     dec_wb_addr, dec_rf_wen   destination
//     dec_is_load, dec_is_csr   instruction class
//     dec_kill                  branch kill of decode
//     cmiss_stall               global pipeline freeze
//     dec_stall                 decode stall (bubble into exe)
//     fwd_rs1_sel/fwd_rs2_sel   0 = register file, k = stage k-1 result
//     sb_busy                   some in-flight entry writes a register
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int  NUM_STAGES = 3,
  parameter int  LOAD_STAGE = 1,
  parameter int  CSR_DRAIN  = 1,
  parameter int  ADDR_W     = 5,
  localparam int SEL_W      = sel_width(NUM_STAGES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dec_valid,
  input  logic [ADDR_W-1:0] dec_rs1_addr,
  input  logic              dec_rs1_oen,
  input  logic [ADDR_W-1:0] dec_rs2_addr,
  input  logic              dec_rs2_oen,
  input  logic [ADDR_W-1:0] dec_wb_addr,
  input  logic              dec_rf_wen,
  input  logic              dec_is_load,
  input  logic              dec_is_csr,
  input  logic              dec_kill,
  input  logic              cmiss_stall,
  output logic              dec_stall,
  output logic [SEL_W-1:0]  fwd_rs1_sel,
  output logic [SEL_W-1:0]  fwd_rs2_sel,
  output logic              sb_busy
);

  localparam int IDX_W = idx_width(NUM_STAGES);

  sb_entry_t [NUM_STAGES-1:0] entries_q, entries_d;

  logic             m1, m2;
  logic [IDX_W-1:0] idx1, idx2;
  logic             ld1, ld2;
  logic             load_haz1, load_haz2;
  logic             csr_block;
  logic             src_stall;

  hazard_match #(.NUM_STAGES(NUM_STAGES), .ADDR_W(ADDR_W)) u_match_rs1 (
    .entries_i (entries_q),
    .addr_i    (dec_rs1_addr),
    .oen_i     (dec_rs1_oen),
    .match_o   (m1),
    .idx_o     (idx1),
    .is_load_o (ld1)
  );

  hazard_match #(.NUM_STAGES(NUM_STAGES), .ADDR_W(ADDR_W)) u_match_rs2 (
    .entries_i (entries_q),
    .addr_i    (dec_rs2_addr),
    .oen_i     (dec_rs2_oen),
    .match_o   (m2),
    .idx_o     (idx2),
    .is_load_o (ld2)
  );

  // Load data is not yet available while the load sits below LOAD_STAGE.
  assign load_haz1 = m1 && ld1 && (int'(idx1) < LOAD_STAGE);
  assign load_haz2 = m2 && ld2 && (int'(idx2) < LOAD_STAGE);

  always_comb begin
    csr_block = 1'b0;
    sb_busy   = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if ((i < CSR_DRAIN) && entries_q[i].valid && entries_q[i].is_csr)
        csr_block = 1'b1;
      if (entries_q[i].valid && entries_q[i].wen)
        sb_busy = 1'b1;
    end
  end

`ifdef HAZARD_SCOREBOARD_BYPASS_EN
  assign src_stall   = load_haz1 || load_haz2;
  assign fwd_rs1_sel = (m1 && !load_haz1) ? SEL_W'(idx1) + SEL_W'(1) : SEL_W'(FWD_RF);
  assign fwd_rs2_sel = (m2 && !load_haz2) ? SEL_W'(idx2) + SEL_W'(1) : SEL_W'(FWD_RF);
`else
  // Full interlock: results are only ever read from the register file.
  logic unused_match_info;
  assign unused_match_info = ^{idx1, idx2, load_haz1, load_haz2};
  assign src_stall   = m1 || m2;
  assign fwd_rs1_sel = SEL_W'(FWD_RF);
  assign fwd_rs2_sel = SEL_W'(FWD_RF);
`endif

  // A killed decode slot never stalls; it turns into a bubble instead.
  assign dec_stall = !dec_kill && (src_stall || csr_block);

  always_comb begin
    entries_d = entries_q;
    if (!cmiss_stall) begin
      for (int i = NUM_STAGES - 1; i >= 1; i--)
        entries_d[i] = entries_q[i-1];
      entries_d[0] = '0;
      if (dec_valid && !dec_stall && !dec_kill) begin
        entries_d[0].valid   = 1'b1;
        entries_d[0].wbaddr  = REG_ADDR_MAX_W'(dec_wb_addr);
        entries_d[0].wen     = dec_rf_wen && (dec_wb_addr != '0);
        entries_d[0].is_load = dec_is_load;
        entries_d[0].is_csr  = dec_is_csr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) entries_q <= '0;
    else       entries_q <= entries_d;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam int NS     = 3;
  localparam int LOADST = 1;
  localparam int CSRD   = 2;
  localparam int AW     = 5;
  localparam int SW     = $clog2(NS + 1);
`ifdef HAZARD_SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          dec_valid;
  logic [AW-1:0] dec_rs1_addr, dec_rs2_addr, dec_wb_addr;
  logic          dec_rs1_oen, dec_rs2_oen;
  logic          dec_rf_wen, dec_is_load, dec_is_csr;
  logic          dec_kill, cmiss_stall;
  logic          dec_stall;
  logic [SW-1:0] fwd_rs1_sel, fwd_rs2_sel;
  logic          sb_busy;

  hazard_scoreboard #(
    .NUM_STAGES(NS), .LOAD_STAGE(LOADST), .CSR_DRAIN(CSRD), .ADDR_W(AW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .dec_valid    (dec_valid),
    .dec_rs1_addr (dec_rs1_addr),
    .dec_rs1_oen  (dec_rs1_oen),
    .dec_rs2_addr (dec_rs2_addr),
    .dec_rs2_oen  (dec_rs2_oen),
    .dec_wb_addr  (dec_wb_addr),
    .dec_rf_wen   (dec_rf_wen),
    .dec_is_load  (dec_is_load),
    .dec_is_csr   (dec_is_csr),
    .dec_kill     (dec_kill),
    .cmiss_stall  (cmiss_stall),
    .dec_stall    (dec_stall),
    .fwd_rs1_sel  (fwd_rs1_sel),
    .fwd_rs2_sel  (fwd_rs2_sel),
    .sb_busy      (sb_busy)
  );

  always #5 clk = ~clk;

  // Model: the instructions in flight, youngest first.
  typedef struct {
    bit v;
    int dst;
    bit wen;
    bit ld;
    bit csr;
  } instr_t;

  instr_t pipe [NS];
  bit     model_ok = 1'b0;
  int     checks = 0;
  int     errs   = 0;

  bit e_stall, e_busy;
  int e_s1, e_s2;
  int a_stall, a_s1, a_s2, a_busy;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Youngest in-flight writer of a source; decides stall/forward from the rules.
  task automatic src_eval(input int addr, input bit oen, output bit haz, output int sel);
    int found;
    found = -1;
    if (oen && addr != 0)
      for (int i = 0; i < NS; i++)
        if (found < 0 && pipe[i].v && pipe[i].wen && pipe[i].dst == addr) found = i;
    if (BYP) begin
      haz = (found >= 0) && pipe[found].ld && (found < LOADST);
      sel = (found >= 0 && !haz) ? found + 1 : 0;
    end else begin
      haz = (found >= 0);
      sel = 0;
    end
  endtask

  task automatic model_eval();
    bit h1, h2, csrb;
    src_eval(int'(dec_rs1_addr), dec_rs1_oen, h1, e_s1);
    src_eval(int'(dec_rs2_addr), dec_rs2_oen, h2, e_s2);
    csrb   = 1'b0;
    e_busy = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (i < CSRD && pipe[i].v && pipe[i].csr) csrb = 1'b1;
      if (pipe[i].v && pipe[i].wen) e_busy = 1'b1;
    end
    e_stall = !dec_kill && (h1 || h2 || csrb);
  endtask

  task automatic model_edge();
    instr_t n;
    if (reset) begin
      foreach (pipe[i]) pipe[i] = '{default: 0};
      model_ok = 1'b1;
    end else if (!cmiss_stall) begin
      n = '{default: 0};
      if (dec_valid && !e_stall && !dec_kill) begin
        n.v   = 1'b1;
        n.dst = int'(dec_wb_addr);
        n.wen = dec_rf_wen && (dec_wb_addr != 0);
        n.ld  = dec_is_load;
        n.csr = dec_is_csr;
      end
      for (int i = NS - 1; i >= 1; i--) pipe[i] = pipe[i-1];
      pipe[0] = n;
    end
  endtask

  // One cycle: compare at the falling edge, advance the model at the rising edge.
  task automatic cyc();
    @(negedge clk);
    model_eval();
    a_stall = int'(dec_stall);
    a_s1    = int'(fwd_rs1_sel);
    a_s2    = int'(fwd_rs2_sel);
    a_busy  = int'(sb_busy);
    if (model_ok) begin
      chk("model_dec_stall", a_stall, int'(e_stall));
      chk("model_fwd_rs1_sel", a_s1, e_s1);
      chk("model_fwd_rs2_sel", a_s2, e_s2);
      chk("model_sb_busy", a_busy, int'(e_busy));
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_dec(input bit v, input int r1, input bit o1, input int r2, input bit o2,
                         input int wb, input bit wen, input bit ld, input bit csr);
    dec_valid    = v;
    dec_rs1_addr = AW'(r1);
    dec_rs1_oen  = o1;
    dec_rs2_addr = AW'(r2);
    dec_rs2_oen  = o2;
    dec_wb_addr  = AW'(wb);
    dec_rf_wen   = wen;
    dec_is_load  = ld;
    dec_is_csr   = csr;
  endtask

  task automatic flush();
    set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0);
    dec_kill    = 1'b0;
    cmiss_stall = 1'b0;
    repeat (NS + 1) cyc();
  endtask

  // Holds the current decode instruction until it stops stalling (bounded).
  task automatic count_stall(output int n);
    bit done;
    n = 0;
    done = 1'b0;
    for (int k = 0; k < 12 && !done; k++) begin
      cyc();
      if (a_stall != 0) n++;
      else done = 1'b1;
    end
    if (!done) chk("stall_bound_expired", n, -1);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    set_dec(1, 1, 1, 2, 1, 3, 1, 0, 0);
    dec_kill    = 1'b0;
    cmiss_stall = 1'b0;
    #1;
    cyc();
    cyc();
    chk("reset_dec_stall", a_stall, 0);
    chk("reset_fwd_rs1_sel", a_s1, 0);
    chk("reset_fwd_rs2_sel", a_s2, 0);
    chk("reset_sb_busy", a_busy, 0);
    reset = 1'b0;
    flush();

    // addi x1 ; add x2,x1,x1
    set_dec(1, 0, 0, 0, 0, 1, 1, 0, 0); cyc();
    set_dec(1, 1, 1, 1, 1, 2, 1, 0, 0); count_stall(n);
    chk("alu_dep_stall_cycles", n, BYP ? 0 : 3);
    chk("alu_dep_rs1_sel", a_s1, BYP ? 1 : 0);
    chk("alu_dep_rs2_sel", a_s2, BYP ? 1 : 0);
    flush();

    // lw x5 ; add x6,x5,x0
    set_dec(1, 0, 0, 0, 0, 5, 1, 1, 0); cyc();
    set_dec(1, 5, 1, 0, 1, 6, 1, 0, 0); count_stall(n);
    chk("load_use_stall_cycles", n, BYP ? 1 : 3);
    chk("load_use_rs1_sel", a_s1, BYP ? 2 : 0);
    flush();

    // addi x0,x0,1 ; add x3,x0,x0
    set_dec(1, 0, 1, 0, 0, 0, 1, 0, 0); cyc();
    set_dec(1, 0, 1, 0, 1, 3, 1, 0, 0); cyc();
    chk("x0_dep_stall", a_stall, 0);
    chk("x0_dep_rs1_sel", a_s1, 0);
    chk("x0_dep_rs2_sel", a_s2, 0);
    chk("x0_dep_sb_busy", a_busy, 0);
    flush();

    // load-use under a 4-cycle freeze
    set_dec(1, 0, 0, 0, 0, 5, 1, 1, 0); cyc();
    set_dec(1, 5, 1, 0, 0, 6, 1, 0, 0);
    cmiss_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("frozen_load_use_stall", a_stall, 1);
    end
    cmiss_stall = 1'b0;
    count_stall(n);
    chk("unfrozen_stall_cycles", n, BYP ? 1 : 3);
    chk("unfrozen_rs1_sel", a_s1, BYP ? 2 : 0);
    flush();

    // csrrw ; add  (drain depth 2)
    set_dec(1, 1, 1, 0, 0, 0, 0, 0, 1); cyc();
    set_dec(1, 9, 1, 10, 1, 11, 1, 0, 0); count_stall(n);
    chk("csr_drain_stall_cycles", n, 2);
    flush();

    // lw x3 ; addi x3 ; add x4,x3 -> youngest writer is the ALU op
    set_dec(1, 0, 0, 0, 0, 3, 1, 1, 0); cyc();
    set_dec(1, 0, 0, 0, 0, 3, 1, 0, 0); cyc();
    set_dec(1, 3, 1, 0, 0, 4, 1, 0, 0); cyc();
    chk("youngest_wins_stall", a_stall, BYP ? 0 : 1);
    chk("youngest_wins_rs1_sel", a_s1, BYP ? 1 : 0);
    flush();

    // lw x7 ; killed add x8,x7 -> no stall, bubble, x8 never in flight
    set_dec(1, 0, 0, 0, 0, 7, 1, 1, 0); cyc();
    set_dec(1, 7, 1, 0, 0, 8, 1, 0, 0);
    dec_kill = 1'b1; cyc();
    chk("kill_suppresses_stall", a_stall, 0);
    dec_kill = 1'b0;
    set_dec(0, 0, 0, 0, 0, 0, 0, 0, 0); cyc();
    chk("kill_busy_from_load", a_busy, 1);
    set_dec(1, 8, 1, 0, 0, 9, 1, 0, 0); cyc();
    chk("kill_bubble_no_x8_stall", a_stall, 0);
    chk("kill_bubble_no_x8_sel", a_s1, 0);
    flush();

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      set_dec(($urandom_range(0, 3) != 0), $urandom_range(0, 5), $urandom_range(0, 1),
              $urandom_range(0, 5), $urandom_range(0, 1), $urandom_range(0, 5),
              $urandom_range(0, 1), ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
      dec_kill    = ($urandom_range(0, 9) == 0);
      cmiss_stall = ($urandom_range(0, 7) == 0);
      reset       = ($urandom_range(0, 149) == 0);
      cyc();
    end
    reset = 1'b0;
    flush();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised decode-stage hazard and bypass controller for the in-order core; replaces the fixed 3-stage exe/mem/wb stall bookkeeping.
- Tracks an in-flight destination scoreboard across NUM_STAGES post-decode stages.
- Raises the decode stall, and selects forwarding sources for rs1/rs2, with configurable load-use latency and CSR serialisation depth.
- Sits between decode and the control-to-data bundle; consumes branch kill and cache-miss stall.

Parameters:
- NUM_STAGES, 3, post-decode stages tracked (index 0 = exe, NUM_STAGES-1 = wb).
- LOAD_STAGE, 1, lowest stage index from which load data is forwardable.
- CSR_DRAIN, 1, a CSR instruction in stage index < CSR_DRAIN stalls decode.
- ADDR_W, 5, register address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- dec_valid  in  1  decode holds a valid instruction
- dec_rs1_addr  in  ADDR_W  source 1 address
- dec_rs1_oen  in  1  source 1 read enable
- dec_rs2_addr  in  ADDR_W  source 2 address
- dec_rs2_oen  in  1  source 2 read enable
- dec_wb_addr  in  ADDR_W  destination address
- dec_rf_wen  in  1  instruction writes the register file
- dec_is_load  in  1  memory read instruction
- dec_is_csr  in  1  serialising CSR instruction
- dec_kill  in  1  branch kill of the decode stage
- cmiss_stall  in  1  global pipeline freeze
- dec_stall  out  1  decode stall; a bubble is inserted into exe
- fwd_rs1_sel  out  SEL_W  0 = register file, k = stage k-1 result
- fwd_rs2_sel  out  SEL_W  as fwd_rs1_sel
- sb_busy  out  1  any in-flight entry with wen=1
- SEL_W = $clog2(NUM_STAGES+1).

Behaviour:
- Scoreboard: NUM_STAGES entries, each {valid, wbaddr, wen, is_load, is_csr}.
- Reset: all entries cleared. Resulting outputs: dec_stall=0, fwd_*_sel=0, sb_busy=0. Reset asserted mid-operation discards all entries in the same edge.
- Clock edge, reset=0, cmiss_stall=1: all entries hold. No shift, no insertion.
- Clock edge, otherwise:
  - entry[i] <= entry[i-1] for i >= 1; entry[NUM_STAGES-1] retires.
  - entry[0] <= bubble (all zero) if dec_stall | dec_kill | !dec_valid; else the decode fields.
  - wen is stored as dec_rf_wen & (dec_wb_addr != 0).
- Source match, stage i: oen & addr != 0 & entry[i].valid & entry[i].wen & entry[i].wbaddr == addr.
- Per source: youngest match (lowest i) wins.
  - Load hazard: the winning entry is_load and i < LOAD_STAGE.
  - Forward: fwd_sel = i+1 if a match exists and there is no load hazard, else 0.
- dec_stall = !dec_kill & (load hazard on rs1 or rs2, or any entry[i].is_csr with i < CSR_DRAIN).
  - dec_kill suppresses the stall.
  - dec_stall is independent of cmiss_stall: the value is held while frozen because entries hold.
- All outputs are combinational from the registered entries and the current decode inputs (zero latency).
- Multiple matching stages: forward from the youngest only; an older load behind a younger ALU writer causes no stall.
- sb_busy = OR over entries of valid & wen.

Optional Feature:
- Macro: HAZARD_SCOREBOARD_BYPASS_EN.
- Defined: forwarding and load-only stalls as above.
- Undefined (full interlock):
  - fwd_rs1_sel and fwd_rs2_sel are tied to 0.
  - dec_stall asserts on any source match in any stage (plus CSR and kill rules unchanged).

Decomposition:
- Shared package Bundle:
  - ScoreboardEntry packed struct.
  - FwdSel type / SEL_W helper.
  - FWD_RF = 0 constant.
- Sub-module hazard_match:
  - Per-source comparator plus priority encoder over entries.
  - Outputs match, index, is_load.
  - Instantiated twice (rs1, rs2).

Test Plan:
- BYPASS_EN, addi x1 then add x2,x1,x1 next cycle -> dec_stall=0, fwd_rs1_sel=1, fwd_rs2_sel=1. Without BYPASS_EN -> dec_stall=1 for 3 cycles, then sel=0.
- lw x5 then add x6,x5,x0 (LOAD_STAGE=1) -> dec_stall=1 for exactly 1 cycle, bubble in entry[0], next cycle fwd_rs1_sel=2.
- addi x0,x0,1 then add x3,x0,x0 -> no stall, sel=0, sb_busy=0.
- Load-use hazard with cmiss_stall held 4 cycles -> entries frozen, dec_stall=1 throughout; released -> 1 bubble, then fwd_rs1_sel=2.
- csrrw (dec_is_csr=1) followed by an add with CSR_DRAIN=2 -> dec_stall=1 for 2 cycles, then 0.
- x3 writers in entry[0] (ALU) and entry[1] (load) -> fwd_rs1_sel=1, no stall. Load hazard with dec_kill=1 -> dec_stall=0, bubble inserted.
